log_rd_arbiter: RTL and testbench
=================================

Name: log_rd_arbiter

Overview:
- Arbitrates the single log-table RAM read port among N_REQ log checkers (CFI checker, DFI checker, and others).
- Each requester uses a level request / done-pulse handshake. The arbiter grants round-robin, issues one read, and returns the data with a one-cycle done pulse.
- Also range/alignment-checks addresses and times out a silent memory, so a hung port cannot stall the checkers.

Parameters:
- N_REQ, 2, number of requesters (2..4)
- N_ADDR_WIDTH, 32, address width
- N_DATA_WIDTH, 32, data width
- LOGTABLE_ADDRINIT, 32'h1FEFF400, lowest legal log address
- LOGTABLE_ADDREND, 32'h1FEFF7FC, highest legal log address (inclusive)
- TIMEOUT_CYCLES, 64, max cycles waiting for i_mem_rd_valid (≥2)

Ports:
- clk, in, 1, clock
- rst, in, 1, reset: synchronous, active-low
- i_req, in, N_REQ, per-requester read request; level, held until its o_done
- i_addr, in, N_REQ*N_ADDR_WIDTH, packed request addresses; requester k uses slice k
- o_gnt, out, N_REQ, one-hot grant; held from ISSUE through RESP
- o_done, out, N_REQ, one-cycle completion pulse to the granted requester
- o_rdata, out, N_DATA_WIDTH, read data; valid while o_done≠0
- o_err, out, 1, completion is an error (bad address or timeout); valid with o_done
- o_mem_rd_en, out, 1, one-cycle read strobe to RAM
- o_mem_addr, out, N_ADDR_WIDTH, read address; valid with o_mem_rd_en, held until RESP
- i_mem_rd_valid, in, 1, RAM data valid
- i_mem_rdata, in, N_DATA_WIDTH, RAM read data
- o_busy, out, 1, state≠IDLE
- o_timeout_cnt, out, 16, saturating count of timeouts

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: o_gnt, o_done, o_rdata, o_err, o_mem_rd_en, o_mem_addr, o_busy, o_timeout_cnt.
  - Reset mid-transaction aborts silently: no done pulse is issued.
  - An i_mem_rd_valid arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any i_req is set, select the first set bit searching from rr_ptr upward with wrap.
  - Latch idx and its address; set o_gnt.
  - Address legal (INIT ≤ addr ≤ END and addr[1:0]==0): go to ISSUE.
  - Otherwise: go to RESP with err=1 and rdata=0. No memory access occurs.
- ISSUE: o_mem_rd_en=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT:
  - i_mem_rd_valid sampled only in this state; memory latency ≥1 cycle.
  - On valid: capture i_mem_rdata, err=0, go to RESP.
  - Else, when timer==TIMEOUT_CYCLES-1: rdata=0, err=1, increment o_timeout_cnt (saturates at 16'hFFFF), go to RESP.
  - If valid and timeout occur in the same cycle, valid wins.
- RESP:
  - o_done[idx]=1 for one cycle, with o_rdata and o_err valid.
  - rr_ptr=(idx+1) mod N_REQ.
  - Drop o_gnt; go to IDLE.
- Latency: from req sampled in IDLE (cycle 0), the done pulse arrives at cycle 3+L for good reads (L = cycles from rd_en to valid) and at cycle 1 for bad addresses.
- Requester obligations:
  - Deassert i_req the cycle after o_done.
  - Keep i_addr stable while i_req is high.
  - The arbiter does not sample i_req in RESP.
- Fairness: with all requesters continuously requesting, grants rotate strictly; no requester waits more than N_REQ-1 transactions.
- Changes to a non-granted requester's i_req during a transaction are ignored until IDLE.
- rr_ptr updates only on completion (including errors).

Decomposition:
- Shared package log_pkg:
  - state encoding (2-bit localparams IDLE/ISSUE/WAIT/RESP)
  - LOGTABLE_ADDRINIT/ADDREND defaults
  - log word size (4 bytes)
- One sub-module, log_rr_select: combinational round-robin picker. Inputs req vector and rr_ptr; outputs one-hot grant and binary idx.
- FSM, timer and datapath live in log_rd_arbiter.

Test Plan:
- Single read: i_req=01, addr0=0x1FEFF410; RAM returns 0xA8AAAAAA at L=2 -> o_mem_addr=0x1FEFF410, o_done=01 at cycle 5, o_rdata=0xA8AAAAAA, o_err=0.
- Contention: i_req=11 held, each dropped the cycle after its own done and reasserted 1 cycle later, for 6 transactions -> grant order 0,1,0,1,0,1.
- Bad addresses: addr=0x1FEFF800 (above END), 0x1FEFF3FC (below INIT), 0x1FEFF402 (unaligned) -> done at cycle 1, o_err=1, o_rdata=0, o_mem_rd_en never asserted.
- Timeout: RAM never responds, TIMEOUT_CYCLES=64 -> done after 64 WAIT cycles, o_err=1, o_timeout_cnt=1. A second timeout gives o_timeout_cnt=2.
- Reset mid-op: rst=0 during WAIT, then i_mem_rd_valid arrives after release -> no done pulse, all outputs 0, rr_ptr=0, next request served normally.
- Boundary: addr=0x1FEFF7FC (END) and 0x1FEFF400 (INIT) -> normal reads, o_err=0. Valid and timeout in the same cycle -> o_err=0 with RAM data.

Source files
------------

// File: rtl/log_pkg.sv
// Shared definitions for the log-table read arbiter: FSM encoding, default
// log-table window and word geometry.
package log_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } log_state_e;

    localparam logic [31:0] LOGTABLE_ADDRINIT_DEF = 32'h1FEF_F400;
    localparam logic [31:0] LOGTABLE_ADDREND_DEF  = 32'h1FEF_F7FC;

    localparam int unsigned LOG_WORD_BYTES = 4;
    localparam int unsigned LOG_ALIGN_BITS = $clog2(LOG_WORD_BYTES);

endpackage

// File: rtl/log_rr_select.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module log_rr_select #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    int unsigned ptr_ext;
    int unsigned best;

    assign ptr_ext = 32'(rr_ptr);

    // Winner is the requester with the smallest rotated distance from rr_ptr.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        best = N_REQ;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (req[k] && ((k + N_REQ - ptr_ext) % N_REQ) < best) begin
                best = (k + N_REQ - ptr_ext) % N_REQ;
                idx  = IDX_W'(k);
            end
        end
        if (best < N_REQ) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/log_rd_arbiter.sv
// Round-robin arbiter for the log-table RAM read port, with address range/alignment
// checking and a read timeout so a silent memory cannot stall the checkers.
module log_rd_arbiter
    import log_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned N_ADDR_WIDTH = 32,
    parameter int unsigned N_DATA_WIDTH = 32,
    parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = N_ADDR_WIDTH'(LOGTABLE_ADDRINIT_DEF),
    parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDREND  = N_ADDR_WIDTH'(LOGTABLE_ADDREND_DEF),
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ*N_ADDR_WIDTH-1:0] i_addr,
    output logic [N_REQ-1:0]              o_gnt,
    output logic [N_REQ-1:0]              o_done,
    output logic [N_DATA_WIDTH-1:0]       o_rdata,
    output logic                          o_err,
    output logic                          o_mem_rd_en,
    output logic [N_ADDR_WIDTH-1:0]       o_mem_addr,
    input  logic                          i_mem_rd_valid,
    input  logic [N_DATA_WIDTH-1:0]       i_mem_rdata,
    output logic                          o_busy,
    output logic [15:0]                   o_timeout_cnt
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    log_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d;
    logic [N_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [N_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    rd_en_q, rd_en_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [15:0]             tcnt_q, tcnt_d;

    logic [N_REQ-1:0]        sel_gnt;
    logic [IDX_W-1:0]        sel_idx;
    logic [N_ADDR_WIDTH-1:0] req_addr;
    logic                    addr_ok;
    logic                    timer_expired;
    logic                    in_resp;

    log_rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req    (i_req),
        .rr_ptr (rr_ptr_q),
        .gnt    (sel_gnt),
        .idx    (sel_idx)
    );

    always_comb begin
        req_addr = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (sel_gnt[k]) begin
                req_addr = i_addr[k*N_ADDR_WIDTH +: N_ADDR_WIDTH];
            end
        end
    end

    assign addr_ok = (req_addr >= LOGTABLE_ADDRINIT) && (req_addr <= LOGTABLE_ADDREND) &&
                     (req_addr[LOG_ALIGN_BITS-1:0] == '0);
    assign timer_expired = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_en_d  = 1'b0;
        timer_d  = timer_q;
        tcnt_d   = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (|i_req) begin
                    idx_d  = sel_idx;
                    gnt_d  = sel_gnt;
                    addr_d = req_addr;
                    if (addr_ok) begin
                        state_d = ISSUE;
                    end else begin
                        // Illegal address completes as an error without touching the RAM.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                rd_en_d = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (i_mem_rd_valid) begin
                    rdata_d = i_mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    if (tcnt_q != 16'hFFFF) begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                rr_ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                gnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            timer_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_en_q  <= rd_en_d;
            timer_q  <= timer_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign in_resp       = (state_q == RESP);
    assign o_done        = in_resp ? gnt_q : '0;
    assign o_rdata       = in_resp ? rdata_q : '0;
    assign o_err         = in_resp & err_q;
    assign o_gnt         = gnt_q;
    assign o_mem_rd_en   = rd_en_q;
    assign o_mem_addr    = addr_q;
    assign o_busy        = (state_q != IDLE);
    assign o_timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_log_rd_arbiter.sv
// Randomized scoreboard bench for log_rd_arbiter against a transaction-level timing model.
module tb_log_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 64;
    localparam logic [31:0] A_INIT = 32'h1FEF_F400;
    localparam logic [31:0] A_END  = 32'h1FEF_F7FC;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    i_req;
    logic [N*AW-1:0] i_addr;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_done;
    logic [DW-1:0]   o_rdata;
    logic            o_err;
    logic            o_mem_rd_en;
    logic [AW-1:0]   o_mem_addr;
    logic            i_mem_rd_valid;
    logic [DW-1:0]   i_mem_rdata;
    logic            o_busy;
    logic [15:0]     o_timeout_cnt;

    always #5 clk = ~clk;

    log_rd_arbiter #(
        .N_REQ          (N),
        .N_ADDR_WIDTH   (AW),
        .N_DATA_WIDTH   (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .o_gnt          (o_gnt),
        .o_done         (o_done),
        .o_rdata        (o_rdata),
        .o_err          (o_err),
        .o_mem_rd_en    (o_mem_rd_en),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rd_valid (i_mem_rd_valid),
        .i_mem_rdata    (i_mem_rdata),
        .o_busy         (o_busy),
        .o_timeout_cnt  (o_timeout_cnt)
    );

    typedef struct {
        int          req;
        logic [31:0] rdata;
        bit          err;
        int          tcnt;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          lat;   // 0 = memory never answers
        logic [31:0] data;
    } plan_t;

    typedef struct {
        int          req;
        logic [31:0] addr;
        int          lat;
        logic [31:0] data;
    } tx_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    tx_t   ep[$];

    int cyc = 0;
    bit rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int tests = 0;
    int fails = 0;
    int hang_cnt = 0;
    bit end_req = 1'b0;
    bit end_done = 1'b0;
    int model_ptr = 0;
    int model_tcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a >= A_INIT) && (a <= A_END) && (a % 4 == 0);
    endfunction

    function automatic int nth_tx(input int k, input int n);
        int c = 0;
        foreach (ep[i]) begin
            if (ep[i].req == k) begin
                if (c == n) return i;
                c++;
            end
        end
        return -1;
    endfunction

    task automatic add_tx(input int k, input logic [31:0] a, input int lat, input logic [31:0] d);
        ep.push_back('{req: k, addr: a, lat: lat, data: d});
    endtask

    // Transaction-level model: who is requesting when the arbiter is idle, who wins by
    // rotation, and how long each kind of completion takes.
    task automatic run_model(input int start);
        int pos[N];
        int avail[N];
        int t;
        int pick;
        int j;
        int done;
        t = start;
        for (int k = 0; k < N; k++) begin
            pos[k]   = 0;
            avail[k] = start;
        end
        for (int n = 0; n < ep.size(); n++) begin
            pick = -1;
            while (pick < 0) begin
                for (int i = 0; i < N; i++) begin
                    int k = (model_ptr + i) % N;
                    if (pick < 0 && nth_tx(k, pos[k]) >= 0 && avail[k] <= t) pick = k;
                end
                if (pick < 0) t = t + 1;
            end
            j = nth_tx(pick, pos[pick]);
            if (!legal(ep[j].addr)) begin
                done = t + 1;
                exp_q.push_back('{req: pick, rdata: 32'h0, err: 1'b1, tcnt: model_tcnt,
                                  done_cyc: done});
            end else begin
                plan_q.push_back('{addr: ep[j].addr, lat: ep[j].lat, data: ep[j].data});
                if (ep[j].lat == 0) begin
                    if (model_tcnt < 65535) model_tcnt++;
                    done = t + 2 + T;
                    exp_q.push_back('{req: pick, rdata: 32'h0, err: 1'b1, tcnt: model_tcnt,
                                      done_cyc: done});
                end else begin
                    done = t + 3 + ep[j].lat;
                    exp_q.push_back('{req: pick, rdata: ep[j].data, err: 1'b0,
                                      tcnt: model_tcnt, done_cyc: done});
                end
            end
            pos[pick]++;
            avail[pick] = done + 2;
            model_ptr   = (pick + 1) % N;
            t           = done + 1;
        end
    endtask

    // Requesters hold req until done, drop it, and come back two cycles after done.
    task automatic run_episode();
        int start;
        int total;
        int completed;
        int budget;
        int j;
        int pos[N];
        int reassert[N];
        bit active[N];
        start = cyc;
        run_model(start);
        total     = ep.size();
        completed = 0;
        budget    = total * (T + 12) + 40;
        for (int k = 0; k < N; k++) begin
            pos[k]      = 0;
            reassert[k] = start;
            active[k]   = 1'b0;
        end
        while (completed < total && cyc <= start + budget) begin
            for (int k = 0; k < N; k++) begin
                if (active[k] && o_done[k]) begin
                    i_req[k]    = 1'b0;
                    active[k]   = 1'b0;
                    pos[k]++;
                    completed++;
                    reassert[k] = cyc + 2;
                end else if (!active[k]) begin
                    j = nth_tx(k, pos[k]);
                    if (j >= 0 && cyc >= reassert[k]) begin
                        i_addr[k*AW +: AW] = ep[j].addr;
                        i_req[k]           = 1'b1;
                        active[k]          = 1'b1;
                    end
                end
            end
            if (completed < total) @(negedge clk);
        end
        if (completed < total) begin
            hang_cnt++;
            i_req = '0;
        end
        ep.delete();
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = A_INIT + 32'(4 * $urandom_range(0, 255));
        case ($urandom_range(0, 9))
            0: a = A_INIT;
            1: a = A_END;
            2: a = A_END + 32'd4;
            3: a = A_INIT - 32'd4;
            4: a = a + 32'd2;
            default: ;
        endcase
        return a;
    endfunction

    function automatic int rand_lat();
        int r = $urandom_range(0, 19);
        if (r == 0) return 0;
        if (r == 1) return T - 1;
        return $urandom_range(1, 6);
    endfunction

    // Monitor and memory responder.
    initial begin
        int          cd = 0;
        logic [31:0] pend_data = 32'h0;
        plan_t       p;
        exp_t        e;
        i_mem_rd_valid = 1'b0;
        i_mem_rdata    = '0;
        forever begin
            @(negedge clk);
            i_mem_rd_valid = 1'b0;
            i_mem_rdata    = $urandom();
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    i_mem_rd_valid = 1'b1;
                    i_mem_rdata    = pend_data;
                end
            end
            if (cyc > 0 && !rst_q) begin
                check("rst_gnt_done", 32'({o_gnt, o_done}), 32'h0);
                check("rst_rdata", o_rdata, 32'h0);
                check("rst_mem_addr", o_mem_addr, 32'h0);
                check("rst_err_rden_busy_tcnt", 32'({o_err, o_mem_rd_en, o_busy, o_timeout_cnt}),
                      32'h0);
            end
            if (o_mem_rd_en) begin
                if (plan_q.size() == 0) begin
                    check("unexpected_rd_en", 32'(o_mem_addr), 32'hFFFF_FFFF);
                end else begin
                    p = plan_q.pop_front();
                    check("mem_addr", o_mem_addr, p.addr);
                    if (p.lat > 0) begin
                        cd        = p.lat;
                        pend_data = p.data;
                    end
                end
            end
            if (o_done != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(o_done), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_vec", 32'(o_done), 32'(1 << e.req));
                    check("gnt_at_done", 32'(o_gnt), 32'(1 << e.req));
                    check("rdata", o_rdata, e.rdata);
                    check("err", 32'(o_err), 32'(e.err));
                    check("timeout_cnt", 32'(o_timeout_cnt), 32'(e.tcnt));
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                end
            end
            if (end_req && !end_done) begin
                check("expected_left", 32'(exp_q.size()), 32'h0);
                check("plan_left", 32'(plan_q.size()), 32'h0);
                check("episode_hang", 32'(hang_cnt), 32'h0);
                end_done = 1'b1;
            end
        end
    end

    initial begin
        rst    = 1'b0;
        i_req  = '0;
        i_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        add_tx(0, 32'h1FEF_F410, 2, 32'hA8AA_AAAA);
        run_episode();

        for (int i = 0; i < 3; i++) begin
            add_tx(0, 32'h1FEF_F500 + 32'(8 * i), $urandom_range(1, 4), $urandom());
            add_tx(1, 32'h1FEF_F600 + 32'(8 * i), $urandom_range(1, 4), $urandom());
        end
        run_episode();

        add_tx(2, 32'h1FEF_F800, 1, 32'h1111_1111);
        add_tx(2, 32'h1FEF_F3FC, 1, 32'h2222_2222);
        add_tx(2, 32'h1FEF_F402, 1, 32'h3333_3333);
        run_episode();

        add_tx(0, 32'h1FEF_F420, 0, 32'h4444_4444);
        add_tx(0, 32'h1FEF_F424, 0, 32'h5555_5555);
        run_episode();

        add_tx(1, A_END, 1, 32'h6666_6666);
        add_tx(1, A_INIT, 1, 32'h7777_7777);
        add_tx(0, 32'h1FEF_F430, T - 1, 32'h8888_8888);
        run_episode();

        // Leave the pointer at 1, then reset in the middle of a read.
        add_tx(0, 32'h1FEF_F440, 3, 32'h9999_9999);
        run_episode();
        i_addr[0 +: AW] = 32'h1FEF_F600;
        i_req[0]        = 1'b1;
        plan_q.push_back('{addr: 32'h1FEF_F600, lat: 8, data: 32'hDEAD_BEEF});
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        i_req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_ptr  = 0;
        model_tcnt = 0;
        repeat (15) @(negedge clk);

        add_tx(1, 32'h1FEF_F700, 2, 32'hAAAA_0001);
        add_tx(2, 32'h1FEF_F704, 1, 32'hAAAA_0002);
        add_tx(0, 32'h1FEF_F708, 0, 32'hAAAA_0003);
        run_episode();

        for (int e = 0; e < 15; e++) begin
            for (int k = 0; k < N; k++) begin
                int cnt = $urandom_range(0, 2);
                for (int c = 0; c < cnt; c++) add_tx(k, rand_addr(), rand_lat(), $urandom());
            end
            if (ep.size() == 0) add_tx(0, rand_addr(), rand_lat(), $urandom());
            run_episode();
        end

        end_req = 1'b1;
        for (int w = 0; w < 5 && !end_done; w++) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
